// File: rtl/swi_debounce_if.sv
// Switch conditioning bundle between raw pins, debouncer and lab top.
// Master side is the debouncer; slave side is its consumer.
interface swi_debounce_if #(
    parameter int NBITS = 8
);
    logic [NBITS-1:0] SWI_RAW;
    logic [NBITS-1:0] SWI;
    logic [NBITS-1:0] SWI_RISE;
    logic [NBITS-1:0] SWI_FALL;
    logic             SETTLING;

    modport master (
        input  SWI_RAW,
        output SWI,
        output SWI_RISE,
        output SWI_FALL,
        output SETTLING
    );

    modport slave (
        output SWI_RAW,
        input  SWI,
        input  SWI_RISE,
        input  SWI_FALL,
        input  SETTLING
    );
endinterface

// File: rtl/swi_debounce.sv
// Slide switch synchronizer + per-bit debounce, feeding top.SWI.
// Define SWI_DEBOUNCE_EDGE_EN to build the SWI_RISE/SWI_FALL pulse registers.
module swi_debounce #(
    parameter int NBITS           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic           clk_2,
    input  logic           reset,
    swi_debounce_if.master sw
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NBITS-1:0] sync_meta;
    logic [NBITS-1:0] sync_q;
    logic [NBITS-1:0] swi_q;
    logic [NBITS-1:0] swi_d;
    logic [CNT_W-1:0] cnt_q [NBITS];
    logic [CNT_W-1:0] cnt_d [NBITS];
    logic             settling_q;
    logic             settling_d;

    always_comb begin
        swi_d      = swi_q;
        settling_d = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != swi_q[i]) begin
                if (cnt_q[i] == LAST) begin
                    swi_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            settling_d = settling_d | (cnt_q[i] != '0) | (cnt_d[i] != '0);
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            sync_meta  <= '0;
            sync_q     <= '0;
            swi_q      <= '0;
            settling_q <= 1'b0;
            for (int i = 0; i < NBITS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_meta  <= sw.SWI_RAW;
            sync_q     <= sync_meta;
            swi_q      <= swi_d;
            settling_q <= settling_d;
            for (int i = 0; i < NBITS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw.SWI      = swi_q;
    assign sw.SETTLING = settling_q;

`ifdef SWI_DEBOUNCE_EDGE_EN
    logic [NBITS-1:0] swi_last;
    logic [NBITS-1:0] rise_q;
    logic [NBITS-1:0] fall_q;

    // Pulses fire the cycle after SWI moves; reset clears swi_last too,
    // so a reset never fakes a falling edge.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            swi_last <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
        end else begin
            swi_last <= swi_q;
            rise_q   <= swi_q & ~swi_last;
            fall_q   <= ~swi_q & swi_last;
        end
    end

    assign sw.SWI_RISE = rise_q;
    assign sw.SWI_FALL = fall_q;
`else
    assign sw.SWI_RISE = '0;
    assign sw.SWI_FALL = '0;
`endif
endmodule
